// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache between the core's fetch port and instruction RAM.
// Hits return combinationally; misses hold the core and fill the whole line word 0 upward.
module icache_dm #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cpu_addr_i,
    output logic [31:0] cpu_instr_o,
    output logic        cpu_hold_o,
    input  logic        flush_i,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_data_i,
    output logic        mem_ce_n_o,
    output logic        mem_oe_n_o,
    input  logic        mem_hold_i,
    output logic [31:0] miss_cnt_o
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam int LA_W  = 30 - OFF_W;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t state, state_nxt;

    logic [31:0]      data_mem [LINES-1:0][WORDS_PER_LINE-1:0];
    logic [TAG_W-1:0] tag_mem  [LINES-1:0];
    logic [LINES-1:0] valid;
    logic [LA_W-1:0]  line_addr;
    logic [OFF_W-1:0] word_cnt;
    logic             pend_flush;

    logic [OFF_W-1:0] cpu_off;
    logic [IDX_W-1:0] cpu_idx;
    logic [TAG_W-1:0] cpu_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             hit;
    logic             miss;
    logic             word_we;
    logic             last_word;

    assign cpu_off   = cpu_addr_i[2 +: OFF_W];
    assign cpu_idx   = cpu_addr_i[2+OFF_W +: IDX_W];
    assign cpu_tag   = cpu_addr_i[31 -: TAG_W];
    assign fill_idx  = line_addr[IDX_W-1:0];
    assign fill_tag  = line_addr[LA_W-1:IDX_W];

    assign hit       = (state == S_IDLE) && valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
    assign miss      = (state == S_IDLE) && !hit;
    assign word_we   = (state == S_WAIT) && !mem_hold_i;
    assign last_word = (word_cnt == OFF_W'(WORDS_PER_LINE - 1));

    assign cpu_instr_o = data_mem[cpu_idx][cpu_off];
    assign miss_cnt_o  = miss_cnt;

    logic [31:0] miss_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cpu_hold_o = 1'b1;
        mem_ce_n_o = 1'b1;
        mem_oe_n_o = 1'b1;
        mem_addr_o = {line_addr, word_cnt, 2'b00};
        case (state)
            S_IDLE: begin
                cpu_hold_o = !hit;
                mem_addr_o = {cpu_addr_i[31:2], 2'b00};
                if (!hit) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                mem_ce_n_o = 1'b0;
                mem_oe_n_o = 1'b0;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                mem_ce_n_o = 1'b0;
                mem_oe_n_o = 1'b0;
                if (!mem_hold_i) state_nxt = last_word ? S_IDLE : S_ISSUE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Later assignments win: a miss drops its own line's valid, and a flush on the
    // completion edge (or earlier in the fill) keeps the filled line invalid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid      <= '0;
            line_addr  <= '0;
            word_cnt   <= '0;
            miss_cnt   <= '0;
            pend_flush <= 1'b0;
        end else begin
            if (flush_i) begin
                valid <= '0;
                if (state != S_IDLE) pend_flush <= 1'b1;
            end
            if (miss) begin
                line_addr      <= cpu_addr_i[31:2+OFF_W];
                word_cnt       <= '0;
                miss_cnt       <= miss_cnt + 32'd1;
                valid[cpu_idx] <= 1'b0;
            end
            if (word_we) begin
                if (last_word) begin
                    if (!pend_flush && !flush_i) valid[fill_idx] <= 1'b1;
                    pend_flush <= 1'b0;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (word_we) data_mem[fill_idx][word_cnt] <= mem_data_i;
        if (word_we && last_word) tag_mem[fill_idx] <= fill_tag;
    end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm with a behavioural instruction RAM whose busy time per
// word is programmable; expected words come from the RAM's address-to-data function.
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_instr;
    logic        cpu_hold;
    logic        flush = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ce_n;
    logic        mem_oe_n;
    logic        mem_hold;
    logic [31:0] miss_cnt;

    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_miss = 0;
    int          hold_cycles = 0;
    int          busy = 0;
    logic        prev_ce_n = 1'b1;
    logic [31:0] prev_addr = '0;
    logic [31:0] issued[$];

    icache_dm #(.LINES(16), .WORDS_PER_LINE(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_addr_i (cpu_addr),
        .cpu_instr_o(cpu_instr),
        .cpu_hold_o (cpu_hold),
        .flush_i    (flush),
        .mem_addr_o (mem_addr),
        .mem_data_i (mem_data),
        .mem_ce_n_o (mem_ce_n),
        .mem_oe_n_o (mem_oe_n),
        .mem_hold_i (mem_hold),
        .miss_cnt_o (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // RAM stays busy for hold_cycles cycles after each new request; garbage while busy.
    assign mem_hold = (busy != 0);
    assign mem_data = mem_hold ? 32'hDEAD_BEEF : ram_word(mem_addr);

    always @(posedge clk) begin
        if (!mem_ce_n && (prev_ce_n || mem_addr != prev_addr)) begin
            busy <= hold_cycles;
            issued.push_back(mem_addr);
        end else if (busy != 0) begin
            busy <= busy - 1;
        end
        prev_ce_n <= mem_ce_n;
        prev_addr <= mem_addr;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        cpu_addr    = '0;
        flush       = 1'b0;
        hold_cycles = 0;
        #1;
        chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_ce_n", {31'd0, mem_ce_n}, 32'd1);
        chk("rst_oe_n", {31'd0, mem_oe_n}, 32'd1);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Called just after a rising edge; counts hold cycles until the word is served.
    task automatic access(input logic [31:0] a, input int exp_stall, input int flush_at,
                          input string tag);
        int n;
        n = 0;
        cpu_addr = a;
        @(negedge clk);
        while (cpu_hold && n < 400) begin
            n++;
            flush = (n == flush_at);
            @(negedge clk);
        end
        flush = 1'b0;
        chk({tag, "_stall"}, n, exp_stall);
        chk({tag, "_instr"}, cpu_instr, ram_word({a[31:2], 2'b00}));
        chk({tag, "_misses"}, miss_cnt, exp_miss);
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();

        issued.delete();
        exp_miss = 1;
        access(32'h0040_0008, 9, 0, "cold");
        chk("cold_nreq", issued.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("cold_addr%0d", i), (issued.size() > i) ? issued[i] : 32'hFFFF_FFFF,
                32'h0040_0000 + 32'(4 * i));

        for (int i = 0; i < 4; i++) begin
            cpu_addr = 32'h0040_0000 + 32'(4 * i);
            @(negedge clk);
            chk($sformatf("hit%0d_hold", i), {31'd0, cpu_hold}, 32'd0);
            chk($sformatf("hit%0d_ce_n", i), {31'd0, mem_ce_n}, 32'd1);
            chk($sformatf("hit%0d_instr", i), cpu_instr, ram_word(cpu_addr));
            @(posedge clk);
            #1;
        end
        chk("hit_misses", miss_cnt, 32'd1);

        do_reset();
        exp_miss = 1;
        access(32'h0040_0000, 9, 0, "conf_a");
        exp_miss = 2;
        access(32'h0040_0100, 9, 0, "conf_b");
        exp_miss = 3;
        access(32'h0040_0000, 9, 0, "conf_a2");

        do_reset();
        hold_cycles = 16;
        exp_miss = 1;
        access(32'h0040_0104, 73, 0, "slow");
        hold_cycles = 0;
        access(32'h0040_0100, 0, 0, "slow_w0");
        access(32'h0040_0108, 0, 0, "slow_w2");
        access(32'h0040_010C, 0, 0, "slow_w3");

        do_reset();
        cpu_addr = 32'h0040_0020;
        repeat (6) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_ce_n", {31'd0, mem_ce_n}, 32'd1);
        chk("midrst_oe_n", {31'd0, mem_oe_n}, 32'd1);
        chk("midrst_hold", {31'd0, cpu_hold}, 32'd1);
        @(posedge clk);
        #1 reset_n = 1'b1;
        exp_miss = 1;
        access(32'h0040_0020, 9, 0, "midrst_refill");

        access(32'h0040_0020, 0, 0, "pre_flush_hit");
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        exp_miss = 2;
        access(32'h0040_0020, 9, 0, "idle_flush");

        exp_miss = 4;
        access(32'h0040_0040, 18, 4, "flush_mid");
        access(32'h0040_0040, 0, 0, "flush_mid_hit");
        exp_miss = 6;
        access(32'h0040_0080, 18, 9, "flush_last");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
